// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types, constants and helpers for the sequential multiplier controller
//
// Contents:
//   SEQ_MUL_WIDTH_DEFAULT : default operand width in bits
//   seq_mul_state_e       : controller state encoding
//   cnt_width()           : bit width of the shift-step counter for a given operand width
package seq_mul_pkg;

    localparam int SEQ_MUL_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } seq_mul_state_e;

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mul_cnt.sv
// rtl/seq_mul_cnt.sv - shift-step counter with clear, increment and wrap at WIDTH
//
// Ports:
//   clk     : rising-edge clock
//   clr     : asynchronous active-high reset, forces count to 0
//   clear   : synchronous clear (operand load)
//   inc     : advance by one shift step
//   count   : completed shift steps, modulo WIDTH
//   at_last : count currently equals WIDTH-1 (the next increment is the final shift)
module seq_mul_cnt
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          clear,
    input  logic                          inc,
    output logic [cnt_width(WIDTH)-1:0]   count,
    output logic                          at_last
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign at_last = (count_q == LAST);
    assign count   = count_q;

    // The final shift wraps to 0 explicitly so non-power-of-two widths
    // behave the same as power-of-two ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = at_last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_mul_ctrl.sv
// rtl/seq_mul_ctrl.sv - shift-and-add multiplier control FSM
//
// Optional feature: define SEQ_MUL_CTRL_EARLY_EXIT_EN to finish as soon as
// the remaining multiplier bits are all zero (checked in TEST).
//
// Ports:
//   clk      : rising-edge clock
//   clr      : asynchronous active-high reset
//   start    : begin a multiplication (sampled in IDLE only)
//   q0       : multiplier LSB from the datapath
//   mq_zero  : remaining multiplier bits are all zero
//   ld_sel   : datapath mux select, 1 = operand load, 0 = shifted value
//   ld_en    : operand load enable
//   add_en   : accumulator add enable
//   shift_en : shift enable
//   busy     : controller not in IDLE
//   done     : one-cycle completion pulse
//   count    : completed shift steps
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = SEQ_MUL_WIDTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          start,
    input  logic                          q0,
    input  logic                          mq_zero,
    output logic                          ld_sel,
    output logic                          ld_en,
    output logic                          add_en,
    output logic                          shift_en,
    output logic                          busy,
    output logic                          done,
    output logic [cnt_width(WIDTH)-1:0]   count
);

    seq_mul_state_e state_q;
    seq_mul_state_e state_d;
    logic           cnt_last;

`ifndef SEQ_MUL_CTRL_EARLY_EXIT_EN
    logic unused_mq_zero;
    assign unused_mq_zero = mq_zero;
`endif

    seq_mul_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .clr     (clr),
        .clear   (state_q == ST_LOAD),
        .inc     (state_q == ST_SHIFT),
        .count   (count),
        .at_last (cnt_last)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_TEST;
            end
            ST_TEST: begin
`ifdef SEQ_MUL_CTRL_EARLY_EXIT_EN
                if (mq_zero) begin
                    state_d = ST_DONE;
                end else if (q0) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_SHIFT;
                end
`else
                state_d = q0 ? ST_ADD : ST_SHIFT;
`endif
            end
            ST_ADD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // cnt_last reflects the count before this step's increment.
                state_d = cnt_last ? ST_DONE : ST_TEST;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded from state_q alone so no input reaches an output.
    always_comb begin
        ld_sel   = 1'b0;
        ld_en    = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                ld_sel = 1'b1;
                ld_en  = 1'b1;
            end
            ST_ADD: begin
                add_en = 1'b1;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            ST_TEST: begin
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/seq_mul_ctrl.md
SEQ_MUL_CTRL -- requirements
Module: seq_mul_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 q0  input  1  current multiplier LSB from the datapath shift register.
REQ-006 mq_zero  input  1  high when all remaining multiplier bits are zero.
REQ-007 ld_sel  output  1  datapath mux select: 1 selects operand load, 0 selects shifted value.
REQ-008 ld_en  output  1  datapath register enable for the operand load.
REQ-009 add_en  output  1  accumulator enable for the add step.
REQ-010 shift_en  output  1  register enable for the shift step.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 count  output  $clog2(WIDTH)  number of completed shift steps.

Function
REQ-014 States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. One state per cycle.
REQ-015 IDLE: start=1 moves to LOAD on the next edge. Otherwise it stays in IDLE. All strobes are 0.
REQ-016 LOAD: ld_sel=1 and ld_en=1 for exactly one cycle; count cleared to 0; next state is TEST.
REQ-017 TEST: no strobes. q0=1 goes to ADD. q0=0 goes to SHIFT.
REQ-018 ADD: add_en=1 for one cycle; next state is SHIFT.
REQ-019 SHIFT: shift_en=1 and ld_sel=0 for one cycle; count increments.
REQ-020 SHIFT exit: when count==WIDTH-1 before the increment, next state is DONE; otherwise next state is TEST.
REQ-021 DONE: done=1 for one cycle, then IDLE.
REQ-022 count holds its value from the last SHIFT through DONE and IDLE until the next LOAD. When the full WIDTH shifts complete, count wraps to 0 and does not saturate.
REQ-023 start is ignored in all states other than IDLE, including DONE. A start held high across DONE begins a new operation from the IDLE cycle that follows.
REQ-024 At most one of ld_en, add_en and shift_en is high in any cycle.
REQ-025 Latency from start sampled to done high is 2 + 2*WIDTH + k cycles, where k is the number of ADD visits.
REQ-026 Outputs are decoded from registered state only, with no combinational path from inputs; busy=0 exactly when done is not in flight and the state is IDLE.

Reset
REQ-027 clr=1 forces IDLE immediately and asynchronously, from any state including mid-operation.
REQ-028 During reset: count=0, busy=0, done=0, and every strobe is 0.
REQ-029 After clr deasserts, the block needs a fresh start; no partial operation resumes.

Configuration
REQ-030 Macro SEQ_MUL_CTRL_EARLY_EXIT_EN, when defined: in TEST, mq_zero=1 goes directly to DONE, and count keeps its current value.
REQ-031 When SEQ_MUL_CTRL_EARLY_EXIT_EN is undefined: mq_zero is ignored, and every operation runs all WIDTH shifts.

Structure
REQ-032 Shared package seq_mul_pkg holds:
- the state enum type;
- the WIDTH default constant;
- the count-width function.
REQ-033 One sub-module, seq_mul_cnt, holds the clear/increment bit counter with async clr; the FSM lives in seq_mul_ctrl.

Verification
REQ-034 WIDTH=8, q0 always 0, start pulsed once: ld_en high in cycle 1 and done high in cycle 18. Eight shift_en pulses occur, with zero add_en pulses.
REQ-035 WIDTH=8, q0 always 1: eight add_en pulses, each immediately followed by shift_en; done occurs in cycle 26.
REQ-036 clr asserted in the cycle of the 4th shift_en: all outputs are 0 at once. start must be re-issued; the repeat run then matches REQ-034 timing.
REQ-037 start held high continuously: done pulses are separated by exactly one IDLE cycle, and start is ignored while busy=1.
REQ-038 With SEQ_MUL_CTRL_EARLY_EXIT_EN defined and mq_zero=1 at the first TEST: done occurs in cycle 3 with count=0.
REQ-039 Every scenario checks that ld_en, add_en and shift_en are mutually exclusive, and that busy matches the state every cycle.
